// File: rtl/simon_iter_core.sv
// simon_iter_core: iterative SIMON block cipher, one round per clock.
// A key is expanded once into a round-key store (one word per cycle);
// blocks are then encrypted or decrypted against that store without
// re-expansion.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid (and its payload) until that edge. key_ready
// and out_valid come straight from registered state. data_ready also
// drops while key_valid is high, so a key offered alongside a block wins.
// data_ready never depends on data_valid.
module simon_iter_core #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 32,
  parameter int ZSEQ = 0
) (
  input  logic           clk,
  input  logic           nR,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*N-1:0] key,
  input  logic           data_valid,
  output logic           data_ready,
  input  logic           enc_dec,
  input  logic [2*N-1:0] block_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] block_out,
  output logic           key_loaded,
  output logic           busy,
  output logic [2:0]     dbg_state
);

  localparam int CW = (T > 1) ? $clog2(T) : 1;

  // z sequences, leftmost character is z[0]
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;
  localparam logic [61:0] Z_SEL = (ZSEQ == 0) ? Z0 :
                                  (ZSEQ == 1) ? Z1 :
                                  (ZSEQ == 2) ? Z2 :
                                  (ZSEQ == 3) ? Z3 : Z4;
  localparam logic [N-1:0] K_C3 = N'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_READY  = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [N-1:0]    k_mem [T];
  logic [CW-1:0]   kcnt;
  logic [CW-1:0]   rcnt;
  logic [2*N-1:0]  st;
  logic            mode_enc;

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  // key schedule step for word kcnt+M
  logic [CW-1:0] kidx_i, kidx_nx, kidx_top, kidx_w;
  logic [5:0]    zi;
  logic [N-1:0]  ktmp, k_new;

  // next round-key word from the words already in the store
  always_comb begin
    kidx_i   = kcnt;
    kidx_nx  = kcnt + CW'(1);
    kidx_top = kcnt + CW'(M - 1);
    kidx_w   = kcnt + CW'(M);
    zi       = 6'(int'(kcnt) % 62);
    ktmp     = ror(k_mem[kidx_top], 3);
    if (M == 4) ktmp = ktmp ^ k_mem[kidx_nx];
    ktmp     = ktmp ^ ror(ktmp, 1);
    k_new    = ~k_mem[kidx_i] ^ ktmp ^ {{(N-1){1'b0}}, Z_SEL[6'd61 - zi]} ^ K_C3;
  end

  // one Feistel round on the current state; decrypt walks the keys backwards
  logic [CW-1:0]  rk_idx;
  logic [N-1:0]   x_cur, y_cur, rk, fx;
  logic [2*N-1:0] st_next, st_final;

  // round function, round-key select and output ordering
  always_comb begin
    x_cur    = st[2*N-1:N];
    y_cur    = st[N-1:0];
    rk_idx   = mode_enc ? rcnt : (CW'(T - 1) - rcnt);
    rk       = k_mem[rk_idx];
    fx       = (rol(x_cur, 1) & rol(x_cur, 8)) ^ rol(x_cur, 2);
    st_next  = {y_cur ^ fx ^ rk, x_cur};
    st_final = mode_enc ? st : {st[N-1:0], st[2*N-1:N]};
  end

  // status decode from the state register
  always_comb begin
    key_ready  = (state == S_IDLE) || (state == S_READY);
    data_ready = (state == S_READY) && key_loaded && !key_valid;
    busy       = (state == S_KEYEXP) || (state == S_RUN) || (state == S_DONE);
    dbg_state  = state;
  end

  // control FSM, key store, cipher state and registered results
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state      <= S_IDLE;
      kcnt       <= '0;
      rcnt       <= '0;
      st         <= '0;
      mode_enc   <= 1'b0;
      key_loaded <= 1'b0;
      out_valid  <= 1'b0;
      block_out  <= '0;
      for (int j = 0; j < T; j++) k_mem[CW'(j)] <= '0;
    end else begin
      case (state)
        S_IDLE, S_READY: begin
          if (key_valid) begin
            for (int j = 0; j < M; j++) k_mem[CW'(j)] <= key[j*N +: N];
            key_loaded <= 1'b0;
            kcnt       <= '0;
            state      <= S_KEYEXP;
          end else if (state == S_READY && data_valid && key_loaded) begin
            st       <= enc_dec ? block_in : {block_in[N-1:0], block_in[2*N-1:N]};
            mode_enc <= enc_dec;
            rcnt     <= '0;
            state    <= S_RUN;
          end
        end
        S_KEYEXP: begin
          k_mem[kidx_w] <= k_new;
          if (kcnt == CW'(T - M - 1)) begin
            kcnt       <= '0;
            key_loaded <= 1'b1;
            state      <= S_READY;
          end else begin
            kcnt <= kcnt + CW'(1);
          end
        end
        S_RUN: begin
          st <= st_next;
          if (rcnt == CW'(T - 1)) begin
            rcnt  <= '0;
            state <= S_DONE;
          end else begin
            rcnt <= rcnt + CW'(1);
          end
        end
        S_DONE: begin
          // first DONE cycle registers the result, then it holds until taken
          if (!out_valid) begin
            out_valid <= 1'b1;
            block_out <= st_final;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core (SIMON 32/64): published vector,
// model-checked random blocks, handshake corner cases and mid-run reset.
module tb_simon_iter_core;
  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;

  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [63:0] K0 = 64'h1918_1110_0908_0100;

  logic           clk = 1'b0;
  logic           nR = 1'b0;
  logic           key_valid = 1'b0;
  logic           key_ready;
  logic [M*N-1:0] key = '0;
  logic           data_valid = 1'b0;
  logic           data_ready;
  logic           enc_dec = 1'b0;
  logic [2*N-1:0] block_in = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] block_out;
  logic           key_loaded;
  logic           busy;
  logic [2:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*N-1:0] exp_q[$];

  simon_iter_core #(.N(N), .M(M), .T(T), .ZSEQ(0)) dut (
    .clk(clk), .nR(nR),
    .key_valid(key_valid), .key_ready(key_ready), .key(key),
    .data_valid(data_valid), .data_ready(data_ready), .enc_dec(enc_dec),
    .block_in(block_in), .out_valid(out_valid), .out_ready(out_ready),
    .block_out(block_out), .key_loaded(key_loaded), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  function automatic logic [15:0] f16(input logic [15:0] v);
    return (rol16(v, 1) & rol16(v, 8)) ^ rol16(v, 2);
  endfunction

  function automatic logic [31:0] model(input logic [63:0] kv, input logic [31:0] blk, input logic enc);
    logic [15:0] ks [32];
    logic [15:0] tmp, x, y;
    for (int i = 0; i < 4; i++) ks[5'(i)] = kv[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      tmp = rol16(ks[5'(i-1)], 13) ^ ks[5'(i-3)];
      tmp = tmp ^ rol16(tmp, 15);
      ks[5'(i)] = 16'hFFFC ^ {15'b0, Z0[6'(61 - ((i - 4) % 62))]} ^ ks[5'(i-4)] ^ tmp;
    end
    x = blk[31:16];
    y = blk[15:0];
    if (enc) begin
      for (int r = 0; r < 32; r++) begin
        tmp = x;
        x   = y ^ f16(x) ^ ks[5'(r)];
        y   = tmp;
      end
    end else begin
      for (int r = 31; r >= 0; r--) begin
        tmp = y;
        y   = x ^ f16(y) ^ ks[5'(r)];
        x   = tmp;
      end
    end
    return {x, y};
  endfunction

  // ---------------- checkers ----------------
  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [63:0] kv, output int waited);
    key       = kv;
    key_valid = 1'b1;
    waited    = 0;
    #1;
    while (!key_ready && waited < 100) begin
      tick();
      waited++;
    end
    check_bit("key_ready_seen", key_ready, 1'b1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key       = {$urandom, $urandom};
  endtask

  task automatic wait_loaded(output int n);
    n = 0;
    while (!key_loaded && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send_block(input logic [31:0] b, input logic enc, input logic [31:0] expv);
    int n;
    exp_q.push_back(expv);
    block_in   = b;
    enc_dec    = enc;
    data_valid = 1'b1;
    n          = 0;
    #1;
    while (!data_ready && n < 100) begin
      tick();
      n++;
    end
    check_bit("data_ready_seen", data_ready, 1'b1);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    block_in   = $urandom;
    enc_dec    = ~enc;
  endtask

  task automatic get_result(input string tag, input int hold);
    int n;
    logic [31:0] expv;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check_int({tag, "_latency"}, n, T + 1);
    expv = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_word({tag, "_hold_value"}, block_out, expv);
      check_bit({tag, "_hold_valid"}, out_valid, 1'b1);
      check_bit({tag, "_hold_drdy"}, data_ready, 1'b0);
    end
    check_word({tag, "_value"}, block_out, expv);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_bit({tag, "_ov_clear"}, out_valid, 1'b0);
    check_bit({tag, "_back_ready"}, data_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w, n, seen;
    logic [31:0] pt, ct;
    logic [63:0] k1, k2;

    // reset values
    repeat (3) tick();
    check_bit("rst_key_ready", key_ready, 1'b1);
    check_bit("rst_data_ready", data_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_key_loaded", key_loaded, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_word("rst_block_out", block_out, 32'h0);
    nR = 1'b1;

    // block offered before any key is never taken
    data_valid = 1'b1;
    block_in   = 32'h1234_5678;
    enc_dec    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit("nokey_data_ready", data_ready, 1'b0);
    end
    data_valid = 1'b0;

    // key expansion: 28 cycles to key_loaded
    send_key(K0, w);
    check_bit("keyexp_busy", busy, 1'b1);
    check_bit("keyexp_key_ready", key_ready, 1'b0);
    wait_loaded(n);
    check_int("keyexp_cycles", n, T - M);

    // published vector, encrypt then decrypt
    send_block(32'h6565_6877, 1'b1, 32'hc69b_e9bb);
    get_result("kat_enc", 0);
    check_bit("between_busy", busy, 1'b0);
    check_bit("between_loaded", key_loaded, 1'b1);
    send_block(32'hc69b_e9bb, 1'b0, 32'h6565_6877);
    get_result("kat_dec", 0);
    check_bit("after_dec_busy", busy, 1'b0);

    // random blocks against the model
    for (int i = 0; i < 3; i++) begin
      pt = $urandom;
      send_block(pt, 1'b1, model(K0, pt, 1'b1));
      get_result("rnd_enc", 0);
      ct = $urandom;
      send_block(ct, 1'b0, model(K0, ct, 1'b0));
      get_result("rnd_dec", 0);
    end

    // result held while out_ready stays low
    pt = $urandom;
    send_block(pt, 1'b1, model(K0, pt, 1'b1));
    get_result("hold", 10);

    // key and block together in READY: key wins
    k1         = {$urandom, $urandom};
    key        = k1;
    key_valid  = 1'b1;
    block_in   = $urandom;
    enc_dec    = 1'b1;
    data_valid = 1'b1;
    #1;
    check_bit("both_data_ready", data_ready, 1'b0);
    check_bit("both_key_ready", key_ready, 1'b1);
    @(posedge clk);
    #1;
    key_valid  = 1'b0;
    data_valid = 1'b0;
    check_bit("both_busy", busy, 1'b1);
    check_bit("both_loaded_clr", key_loaded, 1'b0);
    check_bit("both_data_ready_after", data_ready, 1'b0);
    wait_loaded(n);
    check_int("both_keyexp_cycles", n, T - M);
    pt = $urandom;
    send_block(pt, 1'b1, model(k1, pt, 1'b1));
    get_result("k1_enc", 0);

    // reset in the middle of a run
    pt = $urandom;
    send_block(pt, 1'b1, model(k1, pt, 1'b1));
    repeat (16) tick();
    nR = 1'b0;
    #1;
    check_bit("midrst_key_ready", key_ready, 1'b1);
    check_bit("midrst_data_ready", data_ready, 1'b0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    check_bit("midrst_key_loaded", key_loaded, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_word("midrst_block_out", block_out, 32'h0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) tick();
    nR = 1'b1;
    k2 = {$urandom, $urandom};
    send_key(k2, w);
    check_int("post_rst_key_wait", w, 0);
    seen = 0;
    n    = 0;
    while (!key_loaded && n < 200) begin
      tick();
      n++;
      if (out_valid) seen++;
    end
    check_int("post_rst_keyexp_cycles", n, T - M);
    check_int("post_rst_no_out_valid", seen, 0);
    pt = $urandom;
    send_block(pt, 1'b1, model(k2, pt, 1'b1));
    get_result("post_rst_enc", 0);
    check_int("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
